fpu_cvt_arb: RTL and testbench
==============================

Name: fpu_cvt_arb

Overview:
- Shares the single FP-to-integer conversion unit (cvt_FP_I_mod) among the three FPU pair instances of the low FPU cluster.
- Each FPU pair posts conversion requests (cvtD/cvtE/cvtS/cvt32S/cvt32D/tblD) into a small per-requester queue.
- The block grants one request per cycle round-robin and drives the converter.
- It tracks tag and source through the converter pipeline and returns tagged results, honouring the alten stall and pipeline flush.

Parameters:
- CVT_LAT, 2, converter latency in enabled (non-stalled) cycles from cvt_en to cvt_res valid.
- TAG_W, 9, width of the retire tag carried with each request.
- QDEPTH, 2, entries per requester queue (fixed at 2 in this revision).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill all queued and in-flight requests.
- stall  in  1  converter clock-enable low (fxFRT_alten); freezes issue and tracking.
- reqN_vld  in  1  request valid, N=0..2.
- reqN_rdy  out  1  queue N can accept this cycle.
- reqN_op  in  8  FP op code (fpoperations encodings).
- reqN_data  in  84  operand {exp/hi[83:68], mantissa[67:0]}.
- reqN_tag  in  TAG_W  retire tag.
- cvt_en  out  1  converter enable.
- cvt_A  out  82  converter operand {data[83:68], data[65:0]}; upper 16 bits zeroed for single-width ops.
- cvt_isDBL, cvt_isEXT, cvt_isSNG, cvt_verbatim, cvt_is32b  out  1 each  decoded op class.
- cvt_res  in  65  converter result.
- cvt_alt  in  1  converter alternate/exception flag.
- res_vld  out  1  result valid.
- res_data  out  65  result.
- res_alt  out  1  alternate flag.
- res_bad  out  1  op was not a legal conversion op.
- res_tag  out  TAG_W  tag of result.
- res_src  out  2  requester index 0..2.

Behaviour:
- Reset: all queues empty, rr pointer=0, shadow pipeline invalid. While rst=1, res_vld, cvt_en and every reqN_rdy are 0; rdy=1 the first cycle after rst deasserts.
- Queue: 2-entry FIFO per requester. rdy=(count<2), registered. Push when vld&rdy. Push and pop in the same cycle are both allowed at count 1. vld with rdy=0 is ignored (no overwrite).
- Issue: the cycle after push at the earliest. Issue requires stall=0, flush=0 and a non-empty queue.
  - Winner = first non-empty queue at or after rr pointer (wrapping 2 to 0).
  - Winner's head pops; rr pointer = winner+1 mod 3.
  - Pointer unchanged when nothing issues.
- Op check: a legal op drives cvt_en=1 with decoded class signals. An illegal op pops with cvt_en=0 and still occupies a shadow slot marked bad. Its result returns res_bad=1, res_data=0, res_alt=0.
- Shadow pipeline: CVT_LAT stages of {vld, bad, tag, src}. Advances only when stall=0; fully frozen when stall=1.
- Result: res_vld=1 when the last stage is valid, stall=0 and flush=0. res_data/res_alt are taken from cvt_res/cvt_alt that cycle; fields are held when not valid.
- Latency: push at t gives issue at t+1 and res_vld at t+1+CVT_LAT when no stall and no contention. Each stall cycle adds one.
- Throughput: 1 issue and 1 result per unstalled cycle.
- Flush: in the flush cycle the block clears all queues and shadow valids, drops pushes, suppresses cvt_en and res_vld, and leaves the rr pointer unchanged. Normal operation resumes the next cycle.
- Reset mid-operation behaves as flush and also clears the rr pointer.

Decomposition:
- Package fpu_cvt_pkg:
  - cvt_req_t struct {op, data, tag}.
  - shadow slot struct.
  - Legal-op list function reusing fpoperations constants.
  - Op-class decode function.
- Sub-module fpu_cvt_fifo2: 2-entry FIFO with count, registered rdy, and flush.

Test Plan:
- Single request: req1 cvtD tag 0x15 at t=0, no stall. Expect cvt_en with isDBL=1 at t=1, then res_vld at t=3 with res_tag=0x15, res_src=1.
- Contention: all three requesters push at t=0, rr=0. Expect issue order 0,1,2 on t=1..3 and results t=3..5. Repeat and confirm the next round starts at rr pointer 0.
- Full queue: req2 pushes 3 back-to-back with stall=1. Expect rdy=0 after 2 pushes and the third not accepted; on stall release exactly 2 results return.
- Stall mid-flight: issue at t=1, stall high t=2..4. Expect res_vld at t=6, not during stall; tag and data preserved.
- Illegal op: req0 op=fop_add pushed. Expect cvt_en=0 at issue and res_vld after CVT_LAT with res_bad=1, res_data=0.
- Flush: 2 queued plus 2 in flight, flush pulse. Expect no res_vld for any of them and all rdy=1 the next cycle; a new request completes normally.

Source files
------------

// File: rtl/fpu_cvt_pkg.sv
// fpu_cvt_pkg: shared types and op decode for the FP-to-integer converter
// arbiter. Holds the op codes of the conversion ops, the request and
// shadow-slot records, and the legal-op / op-class decode helpers.
package fpu_cvt_pkg;

   localparam int CVT_TAG_W = 9;   // retire-tag width carried through the queues
   localparam int QDEPTH    = 2;   // entries per requester queue

   // fpoperations encodings used by the conversion path
   localparam logic [7:0] fop_add    = 8'h01;
   localparam logic [7:0] fop_sub    = 8'h02;
   localparam logic [7:0] fop_mul    = 8'h03;
   localparam logic [7:0] fop_cvtD   = 8'h40;
   localparam logic [7:0] fop_cvtE   = 8'h41;
   localparam logic [7:0] fop_cvtS   = 8'h42;
   localparam logic [7:0] fop_cvt32S = 8'h43;
   localparam logic [7:0] fop_cvt32D = 8'h44;
   localparam logic [7:0] fop_tblD   = 8'h45;

   typedef struct packed {
      logic [7:0]           op;
      logic [83:0]          data;
      logic [CVT_TAG_W-1:0] tag;
   } cvt_req_t;

   // One stage of the tracking pipeline that runs alongside the converter
   typedef struct packed {
      logic                 vld;
      logic                 bad;
      logic [CVT_TAG_W-1:0] tag;
      logic [1:0]           src;
   } cvt_shadow_t;

   typedef struct packed {
      logic dbl;
      logic ext;
      logic sng;
      logic verbatim;
      logic is32b;
   } cvt_cls_t;

   function automatic logic cvt_op_legal(input logic [7:0] op);
      case (op)
         fop_cvtD, fop_cvtE, fop_cvtS,
         fop_cvt32S, fop_cvt32D, fop_tblD: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   // tblD is a table lookup on a double operand: the converter passes
   // the operand through untouched, hence verbatim.
   function automatic cvt_cls_t cvt_op_class(input logic [7:0] op);
      cvt_cls_t c;
      c = '0;
      case (op)
         fop_cvtD:   c.dbl = 1'b1;
         fop_cvtE:   c.ext = 1'b1;
         fop_cvtS:   c.sng = 1'b1;
         fop_cvt32S: begin c.sng = 1'b1; c.is32b = 1'b1; end
         fop_cvt32D: begin c.dbl = 1'b1; c.is32b = 1'b1; end
         fop_tblD:   begin c.dbl = 1'b1; c.verbatim = 1'b1; end
         default:    c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fpu_cvt_fifo2.sv
// fpu_cvt_fifo2: 2-entry request FIFO for one converter requester.
// Ports: clk/rst (sync, active-high), flush (empties the FIFO, drops push),
// push/din (accepted only while rdy), pop (head leaves), dout/empty (head),
// rdy (registered "count < QDEPTH", forced low while rst).
module fpu_cvt_fifo2
   import fpu_cvt_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   input  logic     push,
   input  logic     pop,
   input  cvt_req_t din,
   output cvt_req_t dout,
   output logic     empty,
   output logic     rdy
);

   cvt_req_t   mem [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic       rdy_q;
   logic [1:0] cnt;
   logic [1:0] cnt_nxt;
   logic       push_ok;
   logic       pop_ok;

   // rdy_q is the registered full flag; a push at count 1 with a
   // simultaneous pop is fine since rdy_q only looks at the old count.
   assign push_ok = push & rdy_q & ~flush & ~rst;
   assign pop_ok  = pop & (cnt != 2'd0) & ~flush;
   assign cnt_nxt = cnt + {1'b0, push_ok} - {1'b0, pop_ok};
   assign dout    = mem[rd_ptr];
   assign empty   = (cnt == 2'd0);
   // rdy_q idles high through reset so the port reads 1 right after release
   assign rdy     = rdy_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt    <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         rdy_q  <= 1'b1;
      end else begin
         cnt   <= cnt_nxt;
         rdy_q <= (int'(cnt_nxt) < QDEPTH);
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fpu_cvt_arb.sv
// fpu_cvt_arb: shares one FP-to-integer converter between the three FPU
// pairs. Each requester has a 2-entry queue; one head is granted per
// unstalled cycle round-robin and driven to the converter. A shadow
// pipeline of CVT_LAT stages carries {vld,bad,tag,src} so results come
// back tagged with their requester.
// Ports: clk, rst (sync high), flush, stall (converter enable low);
// reqN_{vld,rdy,op,data,tag} for N=0..2; converter side cvt_en, cvt_A,
// cvt_is*/cvt_verbatim out and cvt_res/cvt_alt in; result side res_vld,
// res_data, res_alt, res_bad, res_tag, res_src.
module fpu_cvt_arb
   import fpu_cvt_pkg::*;
#(
   parameter int CVT_LAT = 2,           // >= 1
   parameter int TAG_W   = CVT_TAG_W    // carried in cvt_req_t, keep equal
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall,
   input  logic             req0_vld,
   output logic             req0_rdy,
   input  logic [7:0]       req0_op,
   input  logic [83:0]      req0_data,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_vld,
   output logic             req1_rdy,
   input  logic [7:0]       req1_op,
   input  logic [83:0]      req1_data,
   input  logic [TAG_W-1:0] req1_tag,
   input  logic             req2_vld,
   output logic             req2_rdy,
   input  logic [7:0]       req2_op,
   input  logic [83:0]      req2_data,
   input  logic [TAG_W-1:0] req2_tag,
   output logic             cvt_en,
   output logic [81:0]      cvt_A,
   output logic             cvt_isDBL,
   output logic             cvt_isEXT,
   output logic             cvt_isSNG,
   output logic             cvt_verbatim,
   output logic             cvt_is32b,
   input  logic [64:0]      cvt_res,
   input  logic             cvt_alt,
   output logic             res_vld,
   output logic [64:0]      res_data,
   output logic             res_alt,
   output logic             res_bad,
   output logic [TAG_W-1:0] res_tag,
   output logic [1:0]       res_src
);

   // Reset mid-operation must look like a flush on every path
   logic kill;
   assign kill = flush | rst;

   cvt_req_t   q_din  [3];
   cvt_req_t   q_dout [3];
   logic [2:0] q_push;
   logic [2:0] q_pop;
   logic [2:0] q_empty;
   logic [2:0] q_rdy;

   assign q_din[0] = '{op: req0_op, data: req0_data, tag: req0_tag};
   assign q_din[1] = '{op: req1_op, data: req1_data, tag: req1_tag};
   assign q_din[2] = '{op: req2_op, data: req2_data, tag: req2_tag};
   assign q_push   = {req2_vld, req1_vld, req0_vld};
   assign req0_rdy = q_rdy[0];
   assign req1_rdy = q_rdy[1];
   assign req2_rdy = q_rdy[2];

   for (genvar g = 0; g < 3; g++) begin : g_q
      fpu_cvt_fifo2 u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (q_push[g]),
         .pop   (q_pop[g]),
         .din   (q_din[g]),
         .dout  (q_dout[g]),
         .empty (q_empty[g]),
         .rdy   (q_rdy[g])
      );
   end

   // ---- round-robin grant: first non-empty queue at or after rr ----
   logic [1:0] rr;
   logic [1:0] win;
   logic [2:0] cand;
   logic       found;
   logic       issue;
   logic       legal;
   cvt_req_t   head;
   cvt_cls_t   cls;

   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      cand  = 3'd0;
      for (int k = 0; k < 3; k++) begin
         cand = {1'b0, rr} + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!found && !q_empty[cand[1:0]]) begin
            found = 1'b1;
            win   = cand[1:0];
         end
      end
   end

   always_comb begin
      case (win)
         2'd1:    head = q_dout[1];
         2'd2:    head = q_dout[2];
         default: head = q_dout[0];
      endcase
   end

   assign issue = found & ~stall & ~kill;
   assign legal = cvt_op_legal(head.op);
   assign cls   = cvt_op_class(head.op);
   assign q_pop = {3{issue}} & (3'b001 << win);

   // Illegal ops still pop and take a shadow slot, but never reach the converter
   assign cvt_en       = issue & legal;
   assign cvt_isDBL    = cvt_en & cls.dbl;
   assign cvt_isEXT    = cvt_en & cls.ext;
   assign cvt_isSNG    = cvt_en & cls.sng;
   assign cvt_verbatim = cvt_en & cls.verbatim;
   assign cvt_is32b    = cvt_en & cls.is32b;
   assign cvt_A        = cls.sng ? {16'h0, head.data[65:0]}
                                 : {head.data[83:68], head.data[65:0]};

   always_ff @(posedge clk) begin
      if (rst)        rr <= 2'd0;
      else if (issue) rr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
   end

   // ---- shadow pipeline, frozen with the converter on stall ----
   cvt_shadow_t sh [CVT_LAT];
   cvt_shadow_t last;

   always_ff @(posedge clk) begin
      if (kill) begin
         for (int i = 0; i < CVT_LAT; i++) sh[i].vld <= 1'b0;
      end else if (!stall) begin
         sh[0] <= '{vld: issue, bad: ~legal, tag: head.tag, src: win};
         for (int i = 1; i < CVT_LAT; i++) sh[i] <= sh[i-1];
      end
   end

   assign last = sh[CVT_LAT-1];

   // ---- result: live from the converter when valid, held otherwise ----
   logic [64:0]      live_data;
   logic             live_alt;
   logic [64:0]      hd_data;
   logic             hd_alt;
   logic             hd_bad;
   logic [TAG_W-1:0] hd_tag;
   logic [1:0]       hd_src;

   assign res_vld   = last.vld & ~stall & ~kill;
   assign live_data = last.bad ? 65'd0 : cvt_res;
   assign live_alt  = ~last.bad & cvt_alt;

   assign res_data = res_vld ? live_data : hd_data;
   assign res_alt  = res_vld ? live_alt  : hd_alt;
   assign res_bad  = res_vld ? last.bad  : hd_bad;
   assign res_tag  = res_vld ? last.tag  : hd_tag;
   assign res_src  = res_vld ? last.src  : hd_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         hd_data <= '0;
         hd_alt  <= 1'b0;
         hd_bad  <= 1'b0;
         hd_tag  <= '0;
         hd_src  <= 2'd0;
      end else if (res_vld) begin
         hd_data <= live_data;
         hd_alt  <= live_alt;
         hd_bad  <= last.bad;
         hd_tag  <= last.tag;
         hd_src  <= last.src;
      end
   end

endmodule

// File: tb/tb_fpu_cvt_arb.sv
// Self-checking bench for fpu_cvt_arb: directed scenarios plus a random
// run against a queue-based reference model of the arbiter.
module tb_fpu_cvt_arb;
   import fpu_cvt_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst, flush, stall;
   logic [2:0]  vld;
   logic [2:0]  rdy;
   logic [7:0]  op   [3];
   logic [83:0] data [3];
   logic [8:0]  tag  [3];
   logic        cvt_en, isDBL, isEXT, isSNG, verb, is32b;
   logic [81:0] cvt_A;
   logic [64:0] cvt_res;
   logic        cvt_alt;
   logic        res_vld, res_alt, res_bad;
   logic [64:0] res_data;
   logic [8:0]  res_tag;
   logic [1:0]  res_src;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fpu_cvt_arb #(.CVT_LAT(LAT), .TAG_W(9)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .req0_vld(vld[0]), .req0_rdy(rdy[0]), .req0_op(op[0]), .req0_data(data[0]), .req0_tag(tag[0]),
      .req1_vld(vld[1]), .req1_rdy(rdy[1]), .req1_op(op[1]), .req1_data(data[1]), .req1_tag(tag[1]),
      .req2_vld(vld[2]), .req2_rdy(rdy[2]), .req2_op(op[2]), .req2_data(data[2]), .req2_tag(tag[2]),
      .cvt_en(cvt_en), .cvt_A(cvt_A), .cvt_isDBL(isDBL), .cvt_isEXT(isEXT), .cvt_isSNG(isSNG),
      .cvt_verbatim(verb), .cvt_is32b(is32b), .cvt_res(cvt_res), .cvt_alt(cvt_alt),
      .res_vld(res_vld), .res_data(res_data), .res_alt(res_alt), .res_bad(res_bad),
      .res_tag(res_tag), .res_src(res_src)
   );

   // Reference op table: {legal, dbl, ext, sng, verbatim, is32b}
   function automatic logic [5:0] ref_cls(input logic [7:0] o);
      case (o)
         fop_cvtD:   return 6'b110000;
         fop_cvtE:   return 6'b101000;
         fop_cvtS:   return 6'b100100;
         fop_cvt32S: return 6'b100101;
         fop_cvt32D: return 6'b110001;
         fop_tblD:   return 6'b110010;
         default:    return 6'b000000;
      endcase
   endfunction

   function automatic logic [81:0] ref_A(input logic [7:0] o, input logic [83:0] d);
      logic [5:0] c;
      c = ref_cls(o);
      return c[2] ? {16'h0, d[65:0]} : {d[83:68], d[65:0]};
   endfunction

   function automatic logic [83:0] rnd84();
      return {20'($urandom()), $urandom(), $urandom()};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; flush = 1'b0; stall = 1'b0; vld = 3'b000; cvt_alt = 1'b0;
      repeat (3) tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0; stall = 1'b0; vld = 3'b111;
      for (int i = 0; i < 3; i++) begin op[i] = fop_cvtD; data[i] = rnd84(); tag[i] = 9'(i); end
      cvt_res = '0; cvt_alt = 1'b0;
      tick; tick;
      @(negedge clk);
      n_run++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset_rdy got %b want 000", rdy); end
      n_run++; if (cvt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cvt_en got %b want 0", cvt_en); end
      n_run++; if (res_vld !== 1'b0) begin n_fail++; $display("FAIL reset_res_vld got %b want 0", res_vld); end
      tick;
      rst = 1'b0; vld = 3'b000;
      @(negedge clk);
      n_run++; if (rdy !== 3'b111) begin n_fail++; $display("FAIL reset_release_rdy got %b want 111", rdy); end
      n_run++; if (cvt_en !== 1'b0 || res_vld !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle got en=%b vld=%b want 0 0", cvt_en, res_vld); end
      n_run++; if (res_tag !== 9'h0) begin n_fail++; $display("FAIL reset_res_tag got %h want 000", res_tag); end
   endtask

   task automatic test_single;
      logic [83:0] d;
      do_reset;
      cvt_res = 65'h1_2345_6789_abcd_ef01; cvt_alt = 1'b1;
      d = rnd84();
      tick;                                     // t=0
      vld[1] = 1'b1; op[1] = fop_cvtD; data[1] = d; tag[1] = 9'h015;
      @(negedge clk);
      n_run++; if (cvt_en !== 1'b0) begin n_fail++; $display("FAIL single_t0_en got %b want 0", cvt_en); end
      tick;                                     // t=1
      vld[1] = 1'b0;
      @(negedge clk);
      n_run++; if (cvt_en !== 1'b1) begin n_fail++; $display("FAIL single_t1_en got %b want 1", cvt_en); end
      n_run++; if ({isDBL, isEXT, isSNG, verb, is32b} !== 5'b10000) begin n_fail++; $display("FAIL single_cls got %b want 10000", {isDBL, isEXT, isSNG, verb, is32b}); end
      n_run++; if (cvt_A !== ref_A(fop_cvtD, d)) begin n_fail++; $display("FAIL single_A got %h want %h", cvt_A, ref_A(fop_cvtD, d)); end
      tick;                                     // t=2
      @(negedge clk);
      n_run++; if (res_vld !== 1'b0) begin n_fail++; $display("FAIL single_t2_vld got %b want 0", res_vld); end
      tick;                                     // t=3
      @(negedge clk);
      n_run++; if (res_vld !== 1'b1) begin n_fail++; $display("FAIL single_t3_vld got %b want 1", res_vld); end
      n_run++; if (res_tag !== 9'h015 || res_src !== 2'd1) begin n_fail++; $display("FAIL single_tag_src got %h/%0d want 015/1", res_tag, res_src); end
      n_run++; if (res_data !== 65'h1_2345_6789_abcd_ef01 || res_alt !== 1'b1 || res_bad !== 1'b0) begin n_fail++; $display("FAIL single_data got %h alt=%b bad=%b", res_data, res_alt, res_bad); end
      tick;                                     // t=4
      cvt_res = '0;
      @(negedge clk);
      n_run++; if (res_vld !== 1'b0 || res_tag !== 9'h015) begin n_fail++; $display("FAIL single_hold got vld=%b tag=%h want 0 015", res_vld, res_tag); end
   endtask

   task automatic test_contention;
      logic [83:0] d [3];
      do_reset;
      cvt_res = 65'h0_dead_beef_0000_1111;
      for (int r = 0; r < 2; r++) begin
         tick;                                  // round t=0
         for (int i = 0; i < 3; i++) begin
            d[i] = rnd84(); vld[i] = 1'b1; op[i] = fop_cvtD; data[i] = d[i]; tag[i] = 9'h0A0 + 9'(3*r + i);
         end
         @(negedge clk);
         n_run++; if (cvt_en !== 1'b0 || res_vld !== 1'b0) begin n_fail++; $display("FAIL cont_r%0d_t0 got en=%b vld=%b want 0 0", r, cvt_en, res_vld); end
         for (int c = 1; c <= 5; c++) begin
            tick;
            if (c == 1) vld = 3'b000;
            @(negedge clk);
            n_run++; if (cvt_en !== (c <= 3)) begin n_fail++; $display("FAIL cont_r%0d_t%0d_en got %b want %b", r, c, cvt_en, (c <= 3)); end
            if (c <= 3) begin
               n_run++; if (cvt_A !== ref_A(fop_cvtD, d[c-1])) begin n_fail++; $display("FAIL cont_r%0d_t%0d_order got %h want %h", r, c, cvt_A, ref_A(fop_cvtD, d[c-1])); end
            end
            n_run++; if (res_vld !== (c >= 3)) begin n_fail++; $display("FAIL cont_r%0d_t%0d_vld got %b want %b", r, c, res_vld, (c >= 3)); end
            if (c >= 3) begin
               n_run++; if (res_src !== 2'(c-3) || res_tag !== 9'h0A0 + 9'(3*r + c - 3)) begin n_fail++; $display("FAIL cont_r%0d_t%0d_res got src=%0d tag=%h want %0d %h", r, c, res_src, res_tag, c-3, 9'h0A0 + 9'(3*r + c - 3)); end
            end
         end
      end
   endtask

   task automatic test_full_queue;
      int got;
      do_reset;
      stall = 1'b1;
      for (int p = 0; p < 3; p++) begin
         tick;
         vld[2] = 1'b1; op[2] = fop_cvtS; data[2] = rnd84(); tag[2] = 9'h1C0 + 9'(p);
         @(negedge clk);
         n_run++; if (rdy[2] !== (p < 2)) begin n_fail++; $display("FAIL full_rdy_p%0d got %b want %b", p, rdy[2], (p < 2)); end
         n_run++; if (cvt_en !== 1'b0 || res_vld !== 1'b0) begin n_fail++; $display("FAIL full_stalled_p%0d got en=%b vld=%b want 0 0", p, cvt_en, res_vld); end
      end
      tick;
      vld[2] = 1'b0; stall = 1'b0;
      @(negedge clk);
      n_run++; if (rdy[2] !== 1'b0 || cvt_en !== 1'b1) begin n_fail++; $display("FAIL full_release got rdy=%b en=%b want 0 1", rdy[2], cvt_en); end
      got = 0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin tick; @(negedge clk); end
         if (res_vld === 1'b1) begin
            n_run++; if (res_tag !== 9'h1C0 + 9'(got)) begin n_fail++; $display("FAIL full_tag_%0d got %h want %h", got, res_tag, 9'h1C0 + 9'(got)); end
            got++;
         end
      end
      n_run++; if (got != 2) begin n_fail++; $display("FAIL full_count got %0d want 2", got); end
   endtask

   task automatic test_stall_mid;
      do_reset;
      cvt_res = 65'h1_0f0f_0f0f_f0f0_f0f0; cvt_alt = 1'b0;
      tick;                                     // t=0
      vld[0] = 1'b1; op[0] = fop_cvt32D; data[0] = rnd84(); tag[0] = 9'h0F3;
      tick;                                     // t=1
      vld[0] = 1'b0;
      @(negedge clk);
      n_run++; if (cvt_en !== 1'b1 || is32b !== 1'b1) begin n_fail++; $display("FAIL stall_issue got en=%b is32b=%b want 1 1", cvt_en, is32b); end
      for (int t = 2; t <= 5; t++) begin
         tick;
         stall = (t <= 4);
         @(negedge clk);
         n_run++; if (res_vld !== 1'b0) begin n_fail++; $display("FAIL stall_t%0d_vld got %b want 0", t, res_vld); end
      end
      tick;                                     // t=6
      @(negedge clk);
      n_run++; if (res_vld !== 1'b1) begin n_fail++; $display("FAIL stall_t6_vld got %b want 1", res_vld); end
      n_run++; if (res_tag !== 9'h0F3 || res_src !== 2'd0 || res_data !== 65'h1_0f0f_0f0f_f0f0_f0f0) begin n_fail++; $display("FAIL stall_t6_res got tag=%h src=%0d data=%h", res_tag, res_src, res_data); end
   endtask

   task automatic test_illegal;
      do_reset;
      cvt_res = 65'h0_aaaa_5555_aaaa_5555; cvt_alt = 1'b1;
      tick;                                     // t=0
      vld[0] = 1'b1; op[0] = fop_add; data[0] = rnd84(); tag[0] = 9'h1AB;
      tick;                                     // t=1: bad op issues, legal follows
      op[0] = fop_cvtE; tag[0] = 9'h0CD;
      @(negedge clk);
      n_run++; if (cvt_en !== 1'b0 || {isDBL, isEXT, isSNG, verb, is32b} !== 5'b0) begin n_fail++; $display("FAIL illegal_en got en=%b cls=%b want 0 0", cvt_en, {isDBL, isEXT, isSNG, verb, is32b}); end
      tick;                                     // t=2
      vld[0] = 1'b0;
      @(negedge clk);
      n_run++; if (cvt_en !== 1'b1 || isEXT !== 1'b1) begin n_fail++; $display("FAIL illegal_next_en got en=%b ext=%b want 1 1", cvt_en, isEXT); end
      tick;                                     // t=3
      @(negedge clk);
      n_run++; if (res_vld !== 1'b1 || res_bad !== 1'b1) begin n_fail++; $display("FAIL illegal_res got vld=%b bad=%b want 1 1", res_vld, res_bad); end
      n_run++; if (res_data !== 65'd0 || res_alt !== 1'b0 || res_tag !== 9'h1AB) begin n_fail++; $display("FAIL illegal_fields got data=%h alt=%b tag=%h", res_data, res_alt, res_tag); end
      tick;                                     // t=4
      @(negedge clk);
      n_run++; if (res_vld !== 1'b1 || res_bad !== 1'b0 || res_data !== cvt_res || res_tag !== 9'h0CD) begin n_fail++; $display("FAIL illegal_follow got vld=%b bad=%b tag=%h", res_vld, res_bad, res_tag); end
   endtask

   task automatic test_flush;
      do_reset;
      cvt_res = 65'h0_1234_0000_5678_0000;
      for (int i = 0; i < 3; i++) begin op[i] = fop_cvtD; data[i] = rnd84(); end
      tick;                                     // t=0
      vld = 3'b011; tag[0] = 9'h101; tag[1] = 9'h102;
      tick;                                     // t=1
      vld = 3'b101; tag[0] = 9'h103; tag[2] = 9'h104;
      tick;                                     // t=2
      vld = 3'b000;
      tick;                                     // t=3: flush with a push that must be dropped
      flush = 1'b1; vld = 3'b010; tag[1] = 9'h105;
      @(negedge clk);
      n_run++; if (res_vld !== 1'b0 || cvt_en !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got vld=%b en=%b want 0 0", res_vld, cvt_en); end
      tick;                                     // t=4
      flush = 1'b0; vld = 3'b000;
      @(negedge clk);
      n_run++; if (rdy !== 3'b111) begin n_fail++; $display("FAIL flush_rdy got %b want 111", rdy); end
      n_run++; if (res_vld !== 1'b0 || cvt_en !== 1'b0) begin n_fail++; $display("FAIL flush_t4 got vld=%b en=%b want 0 0", res_vld, cvt_en); end
      tick;                                     // t=5
      vld[2] = 1'b1; tag[2] = 9'h106;
      @(negedge clk);
      n_run++; if (res_vld !== 1'b0 || cvt_en !== 1'b0) begin n_fail++; $display("FAIL flush_t5 got vld=%b en=%b want 0 0", res_vld, cvt_en); end
      tick;                                     // t=6
      vld = 3'b000;
      @(negedge clk);
      n_run++; if (cvt_en !== 1'b1) begin n_fail++; $display("FAIL flush_new_en got %b want 1", cvt_en); end
      tick;                                     // t=7
      @(negedge clk);
      n_run++; if (res_vld !== 1'b0) begin n_fail++; $display("FAIL flush_t7_vld got %b want 0", res_vld); end
      tick;                                     // t=8
      @(negedge clk);
      n_run++; if (res_vld !== 1'b1 || res_tag !== 9'h106 || res_src !== 2'd2) begin n_fail++; $display("FAIL flush_new_res got vld=%b tag=%h src=%0d want 1 106 2", res_vld, res_tag, res_src); end
   endtask

   typedef struct { logic [7:0] op; logic [83:0] d; logic [8:0] t; } mreq_t;
   typedef struct { logic bad; logic [8:0] t; int src; int left; } mfl_t;

   task automatic test_random;
      mreq_t       mq [3][$];
      mfl_t        fl [$];
      mreq_t       it;
      mfl_t        f;
      logic [7:0]  ops [7];
      int          rr_m, w;
      int          sz [3];
      logic [5:0]  c;
      logic        exp_en, exp_rv, seen;
      logic [8:0]  last_tag;
      ops = '{fop_cvtD, fop_cvtE, fop_cvtS, fop_cvt32S, fop_cvt32D, fop_tblD, fop_add};
      do_reset;
      rr_m = 0; seen = 1'b0; last_tag = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick;
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < 3; i++) begin
            vld[i] = 1'($urandom_range(0, 1)); op[i] = ops[$urandom_range(0, 6)];
            data[i] = rnd84(); tag[i] = 9'($urandom());
         end
         cvt_res = {1'($urandom()), $urandom(), $urandom()};
         cvt_alt = 1'($urandom());
         @(negedge clk);
         for (int i = 0; i < 3; i++) sz[i] = mq[i].size();
         for (int i = 0; i < 3; i++) begin
            n_run++; if (rdy[i] !== (sz[i] < 2)) begin n_fail++; $display("FAIL rnd_c%0d_rdy%0d got %b want %b", cyc, i, rdy[i], (sz[i] < 2)); end
         end
         w = -1;
         if (!stall && !flush)
            for (int k = 0; k < 3; k++)
               if (w < 0 && sz[(rr_m + k) % 3] > 0) w = (rr_m + k) % 3;
         c = (w >= 0) ? ref_cls(mq[w][0].op) : 6'b0;
         exp_en = c[5];
         n_run++; if (cvt_en !== exp_en) begin n_fail++; $display("FAIL rnd_c%0d_en got %b want %b", cyc, cvt_en, exp_en); end
         if (exp_en) begin
            n_run++; if (cvt_A !== ref_A(mq[w][0].op, mq[w][0].d) || {isDBL, isEXT, isSNG, verb, is32b} !== c[4:0]) begin n_fail++; $display("FAIL rnd_c%0d_opnd got A=%h cls=%b want %h %b", cyc, cvt_A, {isDBL, isEXT, isSNG, verb, is32b}, ref_A(mq[w][0].op, mq[w][0].d), c[4:0]); end
         end
         exp_rv = (fl.size() > 0) && (fl[0].left == 0) && !stall && !flush;
         n_run++; if (res_vld !== exp_rv) begin n_fail++; $display("FAIL rnd_c%0d_vld got %b want %b", cyc, res_vld, exp_rv); end
         if (exp_rv) begin
            n_run++;
            if (res_tag !== fl[0].t || res_src !== 2'(fl[0].src) || res_bad !== fl[0].bad ||
                res_data !== (fl[0].bad ? 65'd0 : cvt_res) || res_alt !== (fl[0].bad ? 1'b0 : cvt_alt)) begin
               n_fail++; $display("FAIL rnd_c%0d_res got tag=%h src=%0d bad=%b want %h %0d %b", cyc, res_tag, res_src, res_bad, fl[0].t, fl[0].src, fl[0].bad);
            end
            last_tag = fl[0].t; seen = 1'b1;
         end else if (seen) begin
            n_run++; if (res_tag !== last_tag) begin n_fail++; $display("FAIL rnd_c%0d_hold got %h want %h", cyc, res_tag, last_tag); end
         end
         // advance the reference to the state after this clock edge
         if (flush) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            fl.delete();
         end else begin
            if (!stall) begin
               if (fl.size() > 0 && fl[0].left == 0) void'(fl.pop_front());
               foreach (fl[j]) fl[j].left--;
            end
            if (w >= 0) begin
               it = mq[w].pop_front();
               f.bad = !c[5]; f.t = it.t; f.src = w; f.left = LAT - 1;
               fl.push_back(f);
               rr_m = (w + 1) % 3;
            end
            for (int i = 0; i < 3; i++)
               if (vld[i] && sz[i] < 2) begin
                  it.op = op[i]; it.d = data[i]; it.t = tag[i];
                  mq[i].push_back(it);
               end
         end
      end
      tick;
      vld = 3'b000; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0; vld = 3'b000;
      cvt_res = '0; cvt_alt = 1'b0;
      for (int i = 0; i < 3; i++) begin op[i] = '0; data[i] = '0; tag[i] = '0; end
      test_reset;
      test_single;
      test_contention;
      test_full_queue;
      test_stall_mid;
      test_illegal;
      test_flush;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
